// File: rtl/uartlite_pkg.sv
// Shared UART-lite definitions: common widths, defaults and the TX scheduler state encoding.
package uartlite_pkg;

  localparam int unsigned UART_DATA_WIDTH     = 8;
  localparam int unsigned TX_BUSY_TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    POP     = 3'd1,
    WAIT_RD = 3'd2,
    START   = 3'd3,
    WAIT_HI = 3'd4,
    WAIT_LO = 3'd5,
    FLUSH   = 3'd6
  } tx_sched_state_e;

endpackage

// File: rtl/uart_tx_sched.sv
// Drains the TX byte FIFO into the serializer one byte at a time, with flush,
// done interrupt, sticky start-acknowledge timeout and a wrapping byte counter.
module uart_tx_sched
  import uartlite_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = UART_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH    = 16,
  parameter int unsigned BUSY_TIMEOUT = TX_BUSY_TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_enable,
  input  logic                  flush_req,
  input  logic                  err_clr,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic                  fifo_rd_valid,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic                  flush_busy,
  output logic                  tx_irq,
  output logic                  err_timeout,
  output logic [CNT_WIDTH-1:0]  bytes_sent
);

  localparam int unsigned TO_WIDTH = $clog2(BUSY_TIMEOUT);
  // Last WAIT_HI count before the counter would reach BUSY_TIMEOUT-1.
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(BUSY_TIMEOUT - 2);

  tx_sched_state_e       state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_start_q, tx_start_d;
  logic                  flush_busy_q, flush_busy_d;
  logic                  tx_irq_q, tx_irq_d;
  logic                  err_q, err_d;
  logic                  err_set;
  logic [CNT_WIDTH-1:0]  bytes_q, bytes_d;
  logic [TO_WIDTH-1:0]   to_q, to_d;

  // Next-state, capture, counters and registered-output decode.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    bytes_d   = bytes_q;
    to_d      = to_q;
    tx_irq_d  = 1'b0;
    err_set   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d = FLUSH;
        end else if (tx_enable && !fifo_empty && !tx_busy) begin
          state_d = POP;
        end
      end
      POP: state_d = WAIT_RD;
      WAIT_RD: begin
        if (fifo_rd_valid) begin
          tx_data_d = fifo_data;
          state_d   = START;
        end
      end
      START: begin
        to_d    = '0;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_busy) begin
          state_d = WAIT_LO;
        end else begin
          to_d = to_q + TO_WIDTH'(1);
          if (to_q == TO_LAST) begin
            err_set = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          state_d  = IDLE;
          bytes_d  = bytes_q + CNT_WIDTH'(1);
          tx_irq_d = fifo_empty;
        end
      end
      FLUSH: begin
        if (fifo_empty && !fifo_rd_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    err_d        = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    tx_start_d   = (state_d == START);
    flush_busy_d = (state_d == FLUSH);
  end

  // Pop strobe follows live fifo_empty so a flush never over-reads the FIFO.
  always_comb begin
    fifo_rd_en = 1'b0;
    if (state_q == POP) begin
      fifo_rd_en = 1'b1;
    end else if (state_q == FLUSH) begin
      fifo_rd_en = !fifo_empty;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      flush_busy_q <= 1'b0;
      tx_irq_q     <= 1'b0;
      err_q        <= 1'b0;
      bytes_q      <= '0;
      to_q         <= '0;
    end else begin
      state_q      <= state_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      flush_busy_q <= flush_busy_d;
      tx_irq_q     <= tx_irq_d;
      err_q        <= err_d;
      bytes_q      <= bytes_d;
      to_q         <= to_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign flush_busy  = flush_busy_q;
  assign tx_irq      = tx_irq_q;
  assign err_timeout = err_q;
  assign bytes_sent  = bytes_q;

endmodule
